// File: rtl/uart_rx_error_ctrl.sv
// uart_rx_error_ctrl
//   Error-recovery sequencer that sits above the UART rx error manager.
//   It captures unmasked error flags and quiesces the receiver. It raises an
//   interrupt and then waits for a host ack, or recovers automatically.
//   After that it clears the error manager, optionally flushes the rx FIFO,
//   and re-enables the receiver once the line has idled long enough.
//   It also keeps saturating per-type error counters.
//
// Ports
//   clk_i             system clock
//   rst_i             synchronous reset, active-high
//   baud_rate_i       current baud rate (Hz), used to size the idle window
//   framing_error_i   sticky framing flag from the error manager
//   parity_err_i      sticky parity flag from the error manager
//   break_detect_i    sticky break flag from the error manager
//   timeout_detect_i  sticky timeout flag from the error manager
//   rx_filtered_i     filtered rx line
//   frame_active_i    rx state machine is mid-frame
//   err_mask_i        {timeout,break,parity,framing}; 1 = no recovery entry
//   auto_recover_i    1 = skip the host ack
//   err_ack_i         host acknowledge, only honoured while waiting for it
//   cnt_clear_i       zero all error counters
//   error_clear_o     1-cycle clear pulse to the error manager
//   fifo_flush_o      1-cycle rx FIFO flush pulse
//   rx_enable_o       receiver enable
//   irq_o             error interrupt
//   busy_o            sequencer is not idle
//   err_status_o      captured {timeout,break,parity,framing}
//   err_overrun_o     an unmasked error edge arrived while busy
//   frame_err_cnt_o   framing error count (saturating)
//   parity_err_cnt_o  parity error count (saturating)
//   break_cnt_o       break count (saturating)
//
// State      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | receiver running, watching for unmasked errors
// S_WAIT_ACK | error captured, irq held until the host acknowledges
// S_CLEAR    | one cycle: clear error manager, optional FIFO flush
// S_DRAIN    | wait for idle_cycles consecutive idle-line cycles

module uart_rx_error_ctrl #(
  parameter int unsigned CLK_FREQ_HZ      = 100_000_000,
  parameter int unsigned IDLE_BIT_PERIODS = 2,
  parameter int unsigned CNT_WIDTH        = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          baud_rate_i,
  input  logic                 framing_error_i,
  input  logic                 parity_err_i,
  input  logic                 break_detect_i,
  input  logic                 timeout_detect_i,
  input  logic                 rx_filtered_i,
  input  logic                 frame_active_i,
  input  logic [3:0]           err_mask_i,
  input  logic                 auto_recover_i,
  input  logic                 err_ack_i,
  input  logic                 cnt_clear_i,
  output logic                 error_clear_o,
  output logic                 fifo_flush_o,
  output logic                 rx_enable_o,
  output logic                 irq_o,
  output logic                 busy_o,
  output logic [3:0]           err_status_o,
  output logic                 err_overrun_o,
  output logic [CNT_WIDTH-1:0] frame_err_cnt_o,
  output logic [CNT_WIDTH-1:0] parity_err_cnt_o,
  output logic [CNT_WIDTH-1:0] break_cnt_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_ACK = 2'd1;
  localparam logic [1:0] S_CLEAR    = 2'd2;
  localparam logic [1:0] S_DRAIN    = 2'd3;

  localparam logic [31:0]          CLK_FREQ  = 32'(CLK_FREQ_HZ);
  localparam logic [31:0]          IDLE_BITS = 32'(IDLE_BIT_PERIODS);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  logic [1:0]  state_q, state_d;
  logic [3:0]  err_status_q, err_status_d;
  logic        overrun_q, overrun_d;
  logic        rx_enable_q, rx_enable_d;
  logic        irq_q, irq_d;
  logic        error_clear_q, error_clear_d;
  logic        fifo_flush_q, fifo_flush_d;
  logic [31:0] idle_cnt_q, idle_cnt_d;
  logic [31:0] idle_cycles_q, idle_cycles_d;
  logic [3:0]  err_prev_q;

  logic [CNT_WIDTH-1:0] frame_cnt_q, parity_cnt_q, break_cnt_q;

  logic [3:0]  err_vec;
  logic [3:0]  err_act;
  logic [3:0]  err_rise;
  logic        line_idle;
  logic [31:0] bit_cycles;
  logic [63:0] idle_prod;
  logic [31:0] idle_calc;

  assign err_vec   = {timeout_detect_i, break_detect_i, parity_err_i, framing_error_i};
  assign err_act   = err_vec & ~err_mask_i;
  assign err_rise  = err_vec & ~err_prev_q;
  assign line_idle = rx_filtered_i && !frame_active_i;

  // Idle window in clock cycles. A zero baud rate, or a baud rate faster than
  // the clock, falls back to one cycle per bit period. An oversized product
  // saturates rather than wrapping.
  always_comb begin
    bit_cycles = '0;
    if (baud_rate_i != '0) begin
      bit_cycles = CLK_FREQ / baud_rate_i;
    end
    idle_prod = 64'(bit_cycles) * 64'(IDLE_BITS);
    if (baud_rate_i == '0 || idle_prod == '0) begin
      idle_calc = IDLE_BITS;
    end else if (idle_prod[63:32] != '0) begin
      idle_calc = '1;
    end else begin
      idle_calc = idle_prod[31:0];
    end
  end

  always_comb begin
    state_d       = state_q;
    err_status_d  = err_status_q;
    overrun_d     = overrun_q;
    rx_enable_d   = rx_enable_q;
    irq_d         = irq_q;
    error_clear_d = 1'b0;
    fifo_flush_d  = 1'b0;
    idle_cnt_d    = idle_cnt_q;
    idle_cycles_d = idle_cycles_q;

    if (state_q != S_IDLE && (err_rise & ~err_mask_i) != 4'b0) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (err_act != 4'b0) begin
          err_status_d = err_act;
          overrun_d    = 1'b0;
          rx_enable_d  = 1'b0;
          irq_d        = 1'b1;
          if (auto_recover_i) begin
            // Straight into CLEAR, so the clear/flush pulses must start now.
            state_d       = S_CLEAR;
            error_clear_d = 1'b1;
            fifo_flush_d  = err_act[2];
          end else begin
            state_d = S_WAIT_ACK;
          end
        end else if (err_vec != 4'b0) begin
          // Masked-only errors: just clear them at the error manager.
          error_clear_d = 1'b1;
        end
      end

      S_WAIT_ACK: begin
        irq_d = 1'b1;
        if (err_ack_i) begin
          state_d       = S_CLEAR;
          irq_d         = 1'b0;
          error_clear_d = 1'b1;
          fifo_flush_d  = err_status_q[2];
        end
      end

      S_CLEAR: begin
        irq_d         = 1'b0;
        idle_cycles_d = idle_calc;
        idle_cnt_d    = '0;
        state_d       = S_DRAIN;
      end

      S_DRAIN: begin
        if (line_idle) begin
          if (idle_cnt_q == idle_cycles_q - 32'd1) begin
            state_d     = S_IDLE;
            rx_enable_d = 1'b1;
            idle_cnt_d  = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 32'd1;
          end
        end else begin
          idle_cnt_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      err_status_q  <= '0;
      overrun_q     <= 1'b0;
      rx_enable_q   <= 1'b1;
      irq_q         <= 1'b0;
      error_clear_q <= 1'b0;
      fifo_flush_q  <= 1'b0;
      idle_cnt_q    <= '0;
      idle_cycles_q <= '0;
    end else begin
      state_q       <= state_d;
      err_status_q  <= err_status_d;
      overrun_q     <= overrun_d;
      rx_enable_q   <= rx_enable_d;
      irq_q         <= irq_d;
      error_clear_q <= error_clear_d;
      fifo_flush_q  <= fifo_flush_d;
      idle_cnt_q    <= idle_cnt_d;
      idle_cycles_q <= idle_cycles_d;
    end
  end

  // Counters see every rising flag edge regardless of mask or state.
  // Timeout is tracked for edges but not counted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_prev_q   <= '0;
      frame_cnt_q  <= '0;
      parity_cnt_q <= '0;
      break_cnt_q  <= '0;
    end else begin
      err_prev_q <= err_vec;
      if (cnt_clear_i) begin
        frame_cnt_q  <= '0;
        parity_cnt_q <= '0;
        break_cnt_q  <= '0;
      end else begin
        if (err_rise[0] && frame_cnt_q != CNT_MAX) begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
        if (err_rise[1] && parity_cnt_q != CNT_MAX) begin
          parity_cnt_q <= parity_cnt_q + 1'b1;
        end
        if (err_rise[2] && break_cnt_q != CNT_MAX) begin
          break_cnt_q <= break_cnt_q + 1'b1;
        end
      end
    end
  end

  assign error_clear_o    = error_clear_q;
  assign fifo_flush_o     = fifo_flush_q;
  assign rx_enable_o      = rx_enable_q;
  assign irq_o            = irq_q;
  assign busy_o           = (state_q != S_IDLE);
  assign err_status_o     = err_status_q;
  assign err_overrun_o    = overrun_q;
  assign frame_err_cnt_o  = frame_cnt_q;
  assign parity_err_cnt_o = parity_cnt_q;
  assign break_cnt_o      = break_cnt_q;

endmodule

// File: tb/tb_uart_rx_error_ctrl.sv
module tb_uart_rx_error_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] baud;
  logic        fe, pe, bd, td, rx, fa;
  logic [3:0]  mask;
  logic        auto_r, ack, cclr;
  logic        error_clear, fifo_flush, rx_enable, irq, busy, overrun;
  logic [3:0]  status;
  logic [7:0]  fcnt, pcnt, bcnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: counters are just "number of rising edges seen,
  // capped at 255, zeroed by cnt_clear or reset".
  int         m_fe, m_pe, m_bd;
  logic [3:0] m_prev;

  always #5 clk = ~clk;

  uart_rx_error_ctrl #(
    .CLK_FREQ_HZ(100_000_000), .IDLE_BIT_PERIODS(2), .CNT_WIDTH(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .baud_rate_i(baud),
    .framing_error_i(fe), .parity_err_i(pe), .break_detect_i(bd), .timeout_detect_i(td),
    .rx_filtered_i(rx), .frame_active_i(fa), .err_mask_i(mask),
    .auto_recover_i(auto_r), .err_ack_i(ack), .cnt_clear_i(cclr),
    .error_clear_o(error_clear), .fifo_flush_o(fifo_flush), .rx_enable_o(rx_enable),
    .irq_o(irq), .busy_o(busy), .err_status_o(status), .err_overrun_o(overrun),
    .frame_err_cnt_o(fcnt), .parity_err_cnt_o(pcnt), .break_cnt_o(bcnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: update the counter model with what the DUT will sample, then
  // advance. The error manager is emulated by dropping the sticky flags when
  // it sees error_clear.
  task automatic tick();
    logic [3:0] v, r;
    v = {td, bd, pe, fe};
    if (rst) begin
      m_prev = 4'b0; m_fe = 0; m_pe = 0; m_bd = 0;
    end else begin
      r = v & ~m_prev;
      if (cclr) begin
        m_fe = 0; m_pe = 0; m_bd = 0;
      end else begin
        if (r[0]) m_fe = (m_fe < 255) ? m_fe + 1 : 255;
        if (r[1]) m_pe = (m_pe < 255) ? m_pe + 1 : 255;
        if (r[2]) m_bd = (m_bd < 255) ? m_bd + 1 : 255;
      end
      m_prev = v;
    end
    @(posedge clk);
    #1;
    if (error_clear === 1'b1) begin
      fe = 1'b0; pe = 1'b0; bd = 1'b0; td = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; fe = 0; pe = 0; bd = 0; td = 0; ack = 0; cclr = 0; rx = 1; fa = 0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_fcnt"}, 32'(fcnt), m_fe);
    chk({tag, "_pcnt"}, 32'(pcnt), m_pe);
    chk({tag, "_bcnt"}, 32'(bcnt), m_bd);
  endtask

  function automatic int exp_idle(input logic [31:0] b);
    int unsigned q;
    if (b == 32'd0) return 2;
    q = 100_000_000 / b;
    return (q == 0) ? 2 : int'(q * 2);
  endfunction

  // Run the drain phase from the CLEAR cycle; optionally break the idle line
  // once at drain step k (1-based). Returns the number of clocks until
  // rx_enable rises.
  task automatic drain(input int k, input bit use_fa, input int lim, output int n);
    n = 0;
    while (rx_enable !== 1'b1 && n < lim) begin
      n++;
      rx = 1'b1; fa = 1'b0;
      if (k > 0 && n == 1 + k) begin
        if (use_fa) fa = 1'b1;
        else rx = 1'b0;
      end
      tick();
    end
    rx = 1'b1; fa = 1'b0;
  endtask

  typedef struct {
    logic [3:0] vec;
    logic [3:0] msk;
    logic       au;
    logic       e_busy;
    logic [3:0] e_status;
    logic       e_irq;
    logic       e_eclr;
    logic       e_flush;
    logic       e_rxen;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n, idle, k, bsel;
    logic [3:0] v, mk, a;
    logic [31:0] bauds[6];
    int sav_f, sav_p, sav_b;

    tbl[0] = '{4'b0010, 4'b0000, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{4'b1000, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{4'b0011, 4'b0001, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{4'b1001, 4'b0000, 1'b1, 1'b1, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0};

    bauds[0] = 32'd10_000_000; bauds[1] = 32'd25_000_000; bauds[2] = 32'd50_000_000;
    bauds[3] = 32'd0;          bauds[4] = 32'd200_000_000; bauds[5] = 32'd33_000_000;

    baud = 32'd10_000_000; mask = 4'b0; auto_r = 1'b0;
    m_prev = 4'b0; m_fe = 0; m_pe = 0; m_bd = 0;
    do_reset();

    // Reset values
    chk("rst_rxen", 32'(rx_enable), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_eclr", 32'(error_clear), 0);
    chk("rst_flush", 32'(fifo_flush), 0);
    chk("rst_status", 32'(status), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk_cnt("rst");

    // Table: first-cycle response out of IDLE
    for (int i = 0; i < 7; i++) begin
      do_reset();
      mask = tbl[i].msk; auto_r = tbl[i].au;
      {td, bd, pe, fe} = tbl[i].vec;
      tick();
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_status", i), 32'(status), 32'(tbl[i].e_status));
      chk($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].e_irq));
      chk($sformatf("tbl%0d_eclr", i), 32'(error_clear), 32'(tbl[i].e_eclr));
      chk($sformatf("tbl%0d_flush", i), 32'(fifo_flush), 32'(tbl[i].e_flush));
      chk($sformatf("tbl%0d_rxen", i), 32'(rx_enable), 32'(tbl[i].e_rxen));
    end

    // 1: ack path, parity, 10 MHz baud -> 20-cycle idle window
    do_reset();
    baud = 32'd10_000_000; mask = 4'b0; auto_r = 1'b0;
    pe = 1'b1;
    tick();
    chk("t1_irq", 32'(irq), 1);
    chk("t1_status", 32'(status), 4'b0010);
    chk("t1_rxen", 32'(rx_enable), 0);
    chk("t1_pcnt", 32'(pcnt), 1);
    ack = 1'b0;
    tick(); tick();
    chk("t1_irq_hold", 32'(irq), 1);
    chk("t1_busy_hold", 32'(busy), 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t1_eclr", 32'(error_clear), 1);
    chk("t1_flush", 32'(fifo_flush), 0);
    chk("t1_irq_off", 32'(irq), 0);
    drain(0, 1'b0, 40, n);
    chk("t1_latency", n, 21);
    chk("t1_busy_end", 32'(busy), 0);

    // 2: auto path, break -> irq pulse coincides with CLEAR and flush
    sav_b = m_bd;
    auto_r = 1'b1; bd = 1'b1;
    tick();
    chk("t2_irq", 32'(irq), 1);
    chk("t2_eclr", 32'(error_clear), 1);
    chk("t2_flush", 32'(fifo_flush), 1);
    chk("t2_bcnt", 32'(bcnt), sav_b + 1);
    tick();
    chk("t2_irq_pulse", 32'(irq), 0);
    chk("t2_eclr_pulse", 32'(error_clear), 0);
    chk("t2_flush_pulse", 32'(fifo_flush), 0);
    chk("t2_busy", 32'(busy), 1);
    drain(0, 1'b0, 40, n);
    chk("t2_rxen", 32'(rx_enable), 1);

    // 3: line goes low at idle_cnt=15 -> window restarts
    pe = 1'b1;
    tick();
    drain(16, 1'b0, 60, n);
    chk("t3_latency", n, 37);

    // 4: masked timeout only
    sav_f = m_fe; sav_p = m_pe; sav_b = m_bd;
    mask = 4'b1000; auto_r = 1'b0; td = 1'b1;
    tick();
    chk("t4_busy", 32'(busy), 0);
    chk("t4_eclr", 32'(error_clear), 1);
    tick();
    chk("t4_eclr_pulse", 32'(error_clear), 0);
    chk("t4_busy2", 32'(busy), 0);
    chk("t4_fcnt", 32'(fcnt), sav_f);
    chk("t4_pcnt", 32'(pcnt), sav_p);
    chk("t4_bcnt", 32'(bcnt), sav_b);

    // 6: overrun during DRAIN, recapture, then reset from WAIT_ACK
    mask = 4'b0; auto_r = 1'b0; pe = 1'b1;
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    tick(); tick(); tick();
    fe = 1'b1;
    tick();
    chk("t6_overrun", 32'(overrun), 1);
    chk("t6_busy", 32'(busy), 1);
    n = 0;
    while (busy === 1'b1 && n < 60) begin tick(); n++; end
    chk("t6_drain_done", 32'(busy), 0);
    chk("t6_rxen", 32'(rx_enable), 1);
    tick();
    chk("t6_recap_status", 32'(status), 4'b0001);
    chk("t6_recap_irq", 32'(irq), 1);
    chk("t6_recap_ovr", 32'(overrun), 0);
    chk("t6_recap_rxen", 32'(rx_enable), 0);
    do_reset();
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_irq", 32'(irq), 0);
    chk("t6_rst_rxen", 32'(rx_enable), 1);
    chk("t6_rst_status", 32'(status), 0);
    chk_cnt("t6_rst");

    // 5: counter saturation and clear priority
    mask = 4'b1111;
    for (int i = 0; i < 300; i++) begin
      fe = 1'b1; tick();
      fe = 1'b0; tick();
    end
    chk("t5_sat", 32'(fcnt), 255);
    chk_cnt("t5");
    fe = 1'b1; cclr = 1'b1;
    tick();
    cclr = 1'b0;
    chk("t5_clear", 32'(fcnt), 0);
    fe = 1'b0; tick();
    fe = 1'b1; tick();
    chk("t5_after_clear", 32'(fcnt), 1);
    fe = 1'b0; tick();

    // Random transactions against the transaction-level model
    do_reset();
    for (int t = 0; t < 40; t++) begin
      v  = 4'($urandom_range(1, 15));
      mk = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      a  = v & ~mk;
      auto_r = 1'($urandom_range(0, 1));
      bsel = $urandom_range(0, 5);
      baud = bauds[bsel];
      idle = exp_idle(baud);
      mask = mk;
      {td, bd, pe, fe} = v;
      tick();
      if (a == 4'b0) begin
        chk("rnd_masked_busy", 32'(busy), 0);
        chk("rnd_masked_eclr", 32'(error_clear), 1);
        tick();
        chk("rnd_masked_eclr2", 32'(error_clear), 0);
      end else begin
        chk("rnd_status", 32'(status), 32'(a));
        chk("rnd_irq", 32'(irq), 1);
        chk("rnd_rxen", 32'(rx_enable), 0);
        if (!auto_r) begin
          for (int w = 0; w < int'($urandom_range(0, 4)); w++) begin
            tick();
            chk("rnd_wait_irq", 32'(irq), 1);
          end
          ack = 1'b1; tick(); ack = 1'b0;
          chk("rnd_ack_irq", 32'(irq), 0);
        end
        chk("rnd_eclr", 32'(error_clear), 1);
        chk("rnd_flush", 32'(fifo_flush), 32'(a[2]));
        k = ($urandom_range(0, 1) == 1) ? $urandom_range(1, idle) : 0;
        drain(k, 1'($urandom_range(0, 1)), 1 + idle + k + 10, n);
        chk("rnd_latency", n, 1 + idle + k);
      end
      chk_cnt("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
